// File: rtl/v810_icache_if.sv
// V810 instruction-fetch bus: EU fetch port (IA/IREQ/ID/IACK) plus MAU fetch port (MIA/MIREQ/MID/MIACK).
// The slave modport is the cache; the master modport is the surrounding EU/MAU environment.
interface v810_icache_if;
    logic [31:0] IA;
    logic        IREQ;
    logic [31:0] ID;
    logic        IACK;
    logic [31:0] MIA;
    logic        MIREQ;
    logic [31:0] MID;
    logic        MIACK;

    modport slave  (input  IA, IREQ, MID, MIACK, output ID, IACK, MIA, MIREQ);
    modport master (output IA, IREQ, MID, MIACK, input  ID, IACK, MIA, MIREQ);
endinterface

// File: rtl/v810_icache.sv
// Direct-mapped instruction cache between the V810 EU fetch port and the MAU instruction port.
// Define V810_ICACHE_EN to build the cache; otherwise the block is a zero-latency pass-through.
module v810_icache #(
    parameter int unsigned LINES = 128,
    parameter int unsigned TAGW  = 22
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             CE,
    input  logic             FLUSH,
    output logic             BUSY,
    v810_icache_if.slave     bus
);
`ifdef V810_ICACHE_EN
    localparam int unsigned IW = $clog2(LINES);

    typedef enum logic [2:0] {S_SWEEP, S_IDLE, S_LOOKUP, S_MISS, S_FILL} state_t;

    state_t          state;
    logic [TAGW-1:0] tag_mem   [LINES];
    logic [1:0]      valid_mem [LINES];
    logic [31:0]     data_mem  [LINES][2];

    logic [31:2]     addr_q;
    logic [TAGW-1:0] tag_rd;
    logic [1:0]      valid_rd;
    logic [31:0]     data_rd;
    logic [IW-1:0]   cnt;
    logic            flush_pend;
    logic            fill_ack;
    logic            mireq_q;
    logic            busy_q;
    logic [31:0]     id_q;
    logic [31:0]     mia_q;

    logic [IW-1:0]   idx;
    logic [IW-1:0]   in_idx;
    logic            w;
    logic [TAGW-1:0] tag;
    logic            hit;
    logic            lookup_ack;
    logic            unused_ia;

    assign idx       = addr_q[IW+2:3];
    assign w         = addr_q[2];
    assign tag       = addr_q[31:32-TAGW];
    assign in_idx    = bus.IA[IW+2:3];
    assign hit       = valid_rd[w] && (tag_rd == tag);
    assign unused_ia = ^bus.IA[1:0];

    // The hit ack must land in the LOOKUP cycle itself, so it is decoded from the
    // registered array read; a flush in that same cycle suppresses it.
    assign lookup_ack = (state == S_LOOKUP) && hit && !(FLUSH && CE);

    assign bus.IACK  = fill_ack | lookup_ack;
    assign bus.ID    = lookup_ack ? data_rd : id_q;
    assign bus.MIA   = mia_q;
    assign bus.MIREQ = mireq_q;
    assign BUSY      = busy_q;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= S_SWEEP;
            cnt        <= '0;
            flush_pend <= 1'b0;
            fill_ack   <= 1'b0;
            mireq_q    <= 1'b0;
            mia_q      <= '0;
            id_q       <= '0;
            busy_q     <= 1'b1;
        end else if (CE) begin
            case (state)
                S_SWEEP: begin
                    valid_mem[cnt] <= '0;
                    if (FLUSH) begin
                        cnt <= '0;
                    end else if (cnt == IW'(LINES - 1)) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (FLUSH) begin
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_SWEEP;
                    end else if (bus.IREQ) begin
                        addr_q   <= bus.IA[31:2];
                        tag_rd   <= tag_mem[in_idx];
                        valid_rd <= valid_mem[in_idx];
                        data_rd  <= data_mem[in_idx][bus.IA[2]];
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (FLUSH) begin
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_SWEEP;
                    end else if (hit) begin
                        id_q  <= data_rd;
                        state <= S_IDLE;
                    end else begin
                        mireq_q <= 1'b1;
                        mia_q   <= {addr_q, 2'b00};
                        state   <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (FLUSH) flush_pend <= 1'b1;
                    if (bus.MIACK) begin
                        mireq_q           <= 1'b0;
                        fill_ack          <= 1'b1;
                        id_q              <= bus.MID;
                        data_mem[idx][w]  <= bus.MID;
                        // A new tag evicts the line, so the sibling subblock must go invalid.
                        if (tag_rd != tag) begin
                            tag_mem[idx]   <= tag;
                            valid_mem[idx] <= w ? 2'b10 : 2'b01;
                        end else begin
                            valid_mem[idx][w] <= 1'b1;
                        end
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    fill_ack <= 1'b0;
                    if (flush_pend || FLUSH) begin
                        flush_pend <= 1'b0;
                        cnt        <= '0;
                        busy_q     <= 1'b1;
                        state      <= S_SWEEP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_SWEEP;
            endcase
        end
    end
`else
    logic unused_cfg;

    assign bus.MIREQ  = bus.IREQ;
    assign bus.MIA    = {bus.IA[31:2], 2'b00};
    assign bus.ID     = bus.MID;
    assign bus.IACK   = bus.MIACK;
    assign BUSY       = 1'b0;
    assign unused_cfg = (^{CLK, RES, CE, FLUSH, bus.IA[1:0]}) ^ (LINES == 0) ^ (TAGW == 0);
`endif
endmodule

// File: tb/tb_v810_icache.sv
// Directed bench for v810_icache: cache behaviour when V810_ICACHE_EN is defined,
// pass-through wiring otherwise.
module tb_v810_icache;
    logic clk;
    logic rst;
    logic ce;
    logic flush;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    v810_icache_if bus();

    v810_icache #(.LINES(128), .TAGW(22)) dut (
        .CLK   (clk),
        .RES   (rst),
        .CE    (ce),
        .FLUSH (flush),
        .BUSY  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

`ifdef V810_ICACHE_EN
    // EU side must hold IREQ until it has seen IACK.
    assert property (@(posedge clk) disable iff (rst) (bus.IREQ && !bus.IACK) |=> bus.IREQ)
        else $error("EU protocol violation: IREQ dropped before IACK");

    typedef struct {
        logic [31:0] addr;
        logic [31:0] mid;
        int          lat;
        bit          miss;
        logic [31:0] exp_id;
    } fvec_t;

    fvec_t fv[$];

    // Called at posedge+1 of a cycle in which the DUT is IDLE; returns at posedge+1 after the ack cycle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] mid, input int lat,
                         input bit exp_miss, input logic [31:0] exp_id, input int flush_at);
        int          c = 0;
        int          wait_n = 0;
        int          req_cycle = -1;
        int          miack_cycle = -1;
        int          ack_cycle = -1;
        int          nreq = 0;
        logic [31:0] mia_got = '0;
        logic [31:0] id_got = '0;
        logic        prev_req = 1'b0;
        logic        req_at_ack = 1'b0;
        bit          acked = 1'b0;
        string       tag;
        tag = $sformatf("%08h", addr);
        bus.IA   = addr;
        bus.IREQ = 1'b1;
        while (!acked && c < 60) begin
            flush     = (c == flush_at);
            bus.MIACK = 1'b0;
            #1;
            if (bus.MIREQ) begin
                if (!prev_req) begin
                    nreq++;
                    if (req_cycle < 0) begin
                        req_cycle = c;
                        mia_got   = bus.MIA;
                    end
                end
                if (wait_n == lat) begin
                    bus.MIACK   = 1'b1;
                    bus.MID     = mid;
                    miack_cycle = c;
                end
                wait_n++;
            end
            prev_req = bus.MIREQ;
            #1;
            if (bus.IACK) begin
                acked      = 1'b1;
                ack_cycle  = c;
                id_got     = bus.ID;
                req_at_ack = bus.MIREQ;
            end
            @(posedge clk);
            #1;
            c++;
        end
        flush     = 1'b0;
        bus.IREQ  = 1'b0;
        bus.MIACK = 1'b0;
        check({"acked ", tag}, 32'(acked), 32'd1);
        check({"id ", tag}, id_got, exp_id);
        if (exp_miss) begin
            check({"miss mireq count ", tag}, nreq, 1);
            check({"miss mireq cycle ", tag}, req_cycle, 2);
            check({"miss mia ", tag}, mia_got, addr & 32'hFFFF_FFFC);
            check({"miss ack cycle ", tag}, ack_cycle, miack_cycle + 1);
            check({"miss mireq low at ack ", tag}, 32'(req_at_ack), 32'd0);
        end else begin
            check({"hit mireq count ", tag}, nreq, 0);
            check({"hit ack cycle ", tag}, ack_cycle, 1);
        end
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        bit bad = 1'b0;
        while (busy && n < 400) begin
            if (bus.IACK || bus.MIREQ) bad = 1'b1;
            n++;
            @(posedge clk);
            #1;
        end
        check({name, " busy cycles"}, n, 128);
        check({name, " quiet during sweep"}, 32'(bad), 32'd0);
    endtask

    initial begin
        fv.push_back('{32'h8000_0000, 32'h0,           0, 1'b0, 32'h8000_BFE0});
        fv.push_back('{32'h8000_0004, 32'h0000_181F,   0, 1'b1, 32'h0000_181F});
        fv.push_back('{32'h8000_0000, 32'h0,           0, 1'b0, 32'h8000_BFE0});
        fv.push_back('{32'h8000_0004, 32'h0,           0, 1'b0, 32'h0000_181F});
        fv.push_back('{32'h8000_0400, 32'h1234_5678,   1, 1'b1, 32'h1234_5678});
        fv.push_back('{32'h8000_0400, 32'h0,           0, 1'b0, 32'h1234_5678});
        fv.push_back('{32'h8000_0000, 32'h8000_BFE0,   3, 1'b1, 32'h8000_BFE0});
        fv.push_back('{32'h8000_0004, 32'h0000_181F,   0, 1'b1, 32'h0000_181F});
        fv.push_back('{32'h8000_0004, 32'h0,           0, 1'b0, 32'h0000_181F});
        fv.push_back('{32'h0000_0FF8, 32'hCAFE_F00D,   0, 1'b1, 32'hCAFE_F00D});
        fv.push_back('{32'h0000_0FF8, 32'h0,           0, 1'b0, 32'hCAFE_F00D});
        fv.push_back('{32'h8000_0002, 32'h0,           0, 1'b0, 32'h8000_BFE0});
        fv.push_back('{32'h0000_0012, 32'h0BAD_BEEF,   2, 1'b1, 32'h0BAD_BEEF});

        rst       = 1'b1;
        ce        = 1'b1;
        flush     = 1'b0;
        bus.IA    = 32'h8000_0000;
        bus.IREQ  = 1'b1;
        bus.MID   = '0;
        bus.MIACK = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset iack", 32'(bus.IACK), 32'd0);
        check("reset id", bus.ID, 32'h0);
        check("reset mireq", 32'(bus.MIREQ), 32'd0);
        check("reset mia", bus.MIA, 32'h0);
        check("reset busy", 32'(busy), 32'd1);

        rst = 1'b0;
        count_busy("post-reset");
        fetch(32'h8000_0000, 32'h8000_BFE0, 2, 1'b1, 32'h8000_BFE0, -1);

        for (int i = 0; i < fv.size(); i++)
            fetch(fv[i].addr, fv[i].mid, fv[i].lat, fv[i].miss, fv[i].exp_id, -1);

        // Flush while the miss is outstanding: fetch completes, then a full sweep.
        fetch(32'h8000_0400, 32'h5555_AAAA, 5, 1'b1, 32'h5555_AAAA, 3);
        count_busy("flush in miss");
        fetch(32'h8000_0400, 32'h6666_BBBB, 0, 1'b1, 32'h6666_BBBB, -1);

        // Flush during LOOKUP of a hit: no ack, sweep, then the held request misses.
        bus.IA   = 32'h8000_0400;
        bus.IREQ = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush in lookup iack", 32'(bus.IACK), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        count_busy("flush in lookup");
        fetch(32'h8000_0400, 32'h7777_CCCC, 1, 1'b1, 32'h7777_CCCC, -1);

        // Reset while MIREQ is up drops it on the next edge.
        begin
            int n = 0;
            bus.IA   = 32'h0000_2000;
            bus.IREQ = 1'b1;
            while (!bus.MIREQ && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("mid-miss mireq raised", 32'(bus.MIREQ), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("mid-miss reset mireq", 32'(bus.MIREQ), 32'd0);
            check("mid-miss reset busy", 32'(busy), 32'd1);
            check("mid-miss reset iack", 32'(bus.IACK), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`else
    typedef struct {
        logic        ireq;
        logic [31:0] ia;
        logic [31:0] mid;
        logic        miack;
        logic        flush;
        logic        exp_mireq;
        logic [31:0] exp_mia;
        logic [31:0] exp_id;
        logic        exp_iack;
    } pvec_t;

    pvec_t pv[$];

    initial begin
        pv.push_back('{1'b1, 32'h8000_0000, 32'h8000_BFE0, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_BFE0, 1'b1});
        pv.push_back('{1'b1, 32'h8000_0006, 32'h0000_181F, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 32'h0000_181F, 1'b0});
        pv.push_back('{1'b0, 32'h1234_5677, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h1234_5674, 32'hDEAD_BEEF, 1'b1});
        pv.push_back('{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0});
        pv.push_back('{1'b1, 32'h0000_0FFA, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1, 32'h0000_0FF8, 32'hA5A5_A5A5, 1'b1});
        pv.push_back('{1'b1, 32'h8000_0400, 32'h1357_9BDF, 1'b0, 1'b0, 1'b1, 32'h8000_0400, 32'h1357_9BDF, 1'b0});

        rst       = 1'b1;
        ce        = 1'b1;
        flush     = 1'b0;
        bus.IA    = '0;
        bus.IREQ  = 1'b0;
        bus.MID   = '0;
        bus.MIACK = 1'b0;
        @(posedge clk);
        #1;
        check("pass reset busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < pv.size(); i++) begin
            @(posedge clk);
            #1;
            bus.IREQ  = pv[i].ireq;
            bus.IA    = pv[i].ia;
            bus.MID   = pv[i].mid;
            bus.MIACK = pv[i].miack;
            flush     = pv[i].flush;
            #1;
            check($sformatf("pass mireq v%0d", i), 32'(bus.MIREQ), 32'(pv[i].exp_mireq));
            check($sformatf("pass mia v%0d", i), bus.MIA, pv[i].exp_mia);
            check($sformatf("pass id v%0d", i), bus.ID, pv[i].exp_id);
            check($sformatf("pass iack v%0d", i), 32'(bus.IACK), 32'(pv[i].exp_iack));
            check($sformatf("pass busy v%0d", i), 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`endif
endmodule
